square_decode: RTL
==================

Name: square_decode

Overview:
- Receive-side counterpart of the square-wave tone generator in the lab7 audio path.
- Consumes the 16-bit sample stream and recovers the generator's half_period and volume settings.
- Reports a lock flag once the tone is stable; feeds the lab display/self-check logic.
- Sample-rate domain only; no bus interface.

Parameters:
- THRESHOLD, 16'd0, a sample is "high" when unsigned sample > THRESHOLD.
- TIMEOUT, 21'd1048575, run length (in valid samples) at which the tone is declared lost.
- LOCK_COUNT, 2, number of consecutive identical half-period measurements required to assert locked (range 1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- enable  input  1  decoder enable; low forces IDLE
- sample  input  16  incoming sample
- sample_valid  input  1  sample qualifier; one sample accepted per clk with sample_valid=1
- half_period  output  21  last measured half period (run length minus 1)
- volume  output  16  peak sample of the last complete high run
- meas_valid  output  1  one-cycle pulse when half_period/volume update
- locked  output  1  stable-tone indicator
- timeout  output  1  one-cycle pulse when TIMEOUT is reached

Behaviour:
- Reset (rst=0 at posedge clk): all outputs 0, state IDLE, run counter 0, peak 0, match count 0.
- level = (sample > THRESHOLD). This is evaluated only on accepted samples; idle cycles (sample_valid=0) change nothing.
- States:
  - IDLE → WAIT_EDGE when enable=1.
  - Any state → IDLE when enable=0, same cycle. IDLE clears the run counter and match count, forces locked=0, and holds half_period and volume.
- WAIT_EDGE:
  - Tracks prev_level.
  - On the first level change: run_len=1, peak cleared, → MEASURE. The partial first run is never reported.
- MEASURE:
  - Same level: run_len+1, saturating at 2^21-1. If level is high, peak = max(peak, sample).
  - Level change (edge):
    - half_period <= run_len-1 and meas_valid=1 on the next cycle (latency 1 clk from the accepting edge).
    - Falling edge (high→low): volume <= peak.
    - Rising edge (low→high): volume unchanged.
    - Then run_len=1 and peak=sample (or 0 if the new level is low).
- Lock:
  - new measurement == previous measurement: match count +1, saturating at 15.
  - Otherwise match count = 1.
  - locked=1 when match count >= LOCK_COUNT; mismatch drops locked in the same update cycle as meas_valid.
  - The rising-edge and falling-edge runs are both measured. A symmetric generator output therefore yields identical values.
- Timeout:
  - In MEASURE, when run_len reaches TIMEOUT: timeout pulse for 1 clk, locked=0, match count=0, → WAIT_EDGE.
  - If an edge and the TIMEOUT condition occur on the same accepted sample, the edge wins and no timeout is raised.
- Inverse relation: the generator holds each level for half_period+1 samples, so the decoder reports the programmed half_period exactly.
- Reset mid-run: everything is discarded; the first measurement needs two further edges.
- A sample of exactly THRESHOLD is low.

Optional Feature:
- Macro: SQUARE_DECODE_DEGLITCH_EN.
- When defined:
  - A level change is accepted only after the new level persists for 3 consecutive accepted samples.
  - Run length is credited back, so measurements are unaffected for clean input.
  - Shorter glitches are absorbed into the current run: they count toward run_len, and peak ignores glitch samples.
  - Measurement latency becomes 3 accepted samples + 1 clk after the true edge.
- When undefined: every level change is an edge, and latency is 1 clk.

Test Plan:
- Generator with half_period=4, volume=16'h1234, sample_valid=1 every clk:
  - Runs of 5 samples give half_period=4 on each meas_valid.
  - volume=16'h1234 after the first falling edge.
  - locked=1 at the 2nd measurement.
- Mid-stream change of half_period 4→9:
  - First measurement 9 drops locked.
  - locked reasserts after 2 consecutive 9s.
  - No stale value is reported.
- TIMEOUT=100, sample held at 0 after lock:
  - timeout pulses exactly once at the 100th low sample.
  - locked=0, state WAIT_EDGE; a subsequent tone relocks after 3 edges.
- sample_valid toggling 1/0 every clk with half_period=4:
  - Measurement stays 4; idle cycles are not counted.
- enable dropped for 10 clks, and separately rst=0 pulsed mid-run:
  - locked=0, meas_valid silent.
  - half_period/volume hold on enable drop and clear to 0 on reset.
  - Reacquisition needs two edges.
- SQUARE_DECODE_DEGLITCH_EN defined, half_period=20 tone with a 2-sample zero glitch inside a high run:
  - Measurements remain 20, locked stays 1.
  - Without the macro, measurements break and locked drops.

Source files
------------

// File: rtl/square_decode_if.sv
// square_decode_if: sample stream in, recovered tone measurements out
//   master drives enable/sample/sample_valid and observes the measurements
//   slave (the decoder) observes the stream and drives the measurements
interface square_decode_if;
  logic        enable;
  logic [15:0] sample;
  logic        sample_valid;
  logic [20:0] half_period;
  logic [15:0] volume;
  logic        meas_valid;
  logic        locked;
  logic        timeout;
  modport master (output enable, sample, sample_valid, input half_period, volume, meas_valid, locked, timeout);
  modport slave (input enable, sample, sample_valid, output half_period, volume, meas_valid, locked, timeout);
endinterface

// File: rtl/square_decode.sv
// square_decode: recovers half_period/volume of a square tone from a sample stream and flags lock
//   clk, rst (sync, active-low); bus: enable, sample, sample_valid in; half_period, volume,
//   meas_valid, locked, timeout out. SQUARE_DECODE_DEGLITCH_EN: edges need 3 persisting samples.
module square_decode #(
  parameter logic [15:0] THRESHOLD  = 16'd0,
  parameter logic [20:0] TIMEOUT    = 21'd1048575,
  parameter int          LOCK_COUNT = 2
) (
  input logic             clk,
  input logic             rst,
  square_decode_if.slave  bus
);
`ifdef SQUARE_DECODE_DEGLITCH_EN
  localparam logic [1:0] DG = 2'd3;
`else
  localparam logic [1:0] DG = 2'd1;
`endif
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;
  state_t      state_q, state_d;
  logic        prev_q, prev_d, have_q, have_d;
  logic [1:0]  pend_q, pend_d, cnt;
  logic [20:0] run_q, run_d, half_q, half_d, run_inc, meas_half;
  logic [15:0] peak_q, peak_d, ppk_q, ppk_d, vol_q, vol_d, pk_new;
  logic [3:0]  match_q, match_d;
  logic        mv_q, mv_d, lock_q, lock_d, to_q, to_d;
  logic        lvl, diff, edge_hit, tmo;
  assign lvl       = bus.sample > THRESHOLD;
  assign diff      = lvl != prev_q;
  // consecutive accepted samples disagreeing with the confirmed level
  assign cnt       = diff ? pend_q + 2'd1 : 2'd0;
  assign edge_hit  = bus.sample_valid && have_q && diff && cnt == DG;
  assign run_inc   = &run_q ? run_q : run_q + 21'd1;
  // pending samples were absorbed into the old run; hand them back to the new one
  assign meas_half = run_q - {19'd0, DG};
  assign pk_new    = lvl ? (bus.sample > ppk_q ? bus.sample : ppk_q) : 16'd0;
  assign tmo       = state_q == MEASURE && bus.sample_valid && !edge_hit && run_inc == TIMEOUT;
  always_ff @(posedge clk)
    state_q <= !rst ? IDLE : state_d;
  always_comb
    state_d = !bus.enable ? IDLE : state_q == IDLE ? WAIT_EDGE : edge_hit ? MEASURE : tmo ? WAIT_EDGE : state_q;
  always_comb begin
    prev_d  = prev_q;
    have_d  = have_q;
    pend_d  = pend_q;
    run_d   = run_q;
    peak_d  = peak_q;
    ppk_d   = ppk_q;
    half_d  = half_q;
    vol_d   = vol_q;
    match_d = match_q;
    lock_d  = lock_q;
    mv_d    = 1'b0;
    to_d    = 1'b0;
    if (!bus.enable || state_q == IDLE) begin
      run_d   = '0;
      match_d = '0;
      lock_d  = 1'b0;
      have_d  = 1'b0;
      pend_d  = '0;
      ppk_d   = '0;
    end else if (bus.sample_valid) begin
      have_d = 1'b1;
      if (!have_q) begin
        prev_d = lvl;
        pend_d = '0;
        ppk_d  = '0;
      end else if (edge_hit) begin
        prev_d = lvl;
        pend_d = '0;
        ppk_d  = '0;
        run_d  = {19'd0, DG};
        peak_d = pk_new;
        if (state_q == MEASURE) begin
          mv_d    = 1'b1;
          half_d  = meas_half;
          vol_d   = lvl ? vol_q : peak_q;
          match_d = meas_half == half_q ? (match_q == 4'd15 ? match_q : match_q + 4'd1) : 4'd1;
          lock_d  = match_d >= LC;
        end
      end else begin
        pend_d = cnt;
        ppk_d  = diff ? pk_new : 16'd0;
        if (state_q == MEASURE) begin
          run_d  = run_inc;
          peak_d = lvl && !diff && bus.sample > peak_q ? bus.sample : peak_q;
          if (tmo) begin
            to_d    = 1'b1;
            lock_d  = 1'b0;
            match_d = '0;
          end
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      prev_q  <= 1'b0;
      have_q  <= 1'b0;
      pend_q  <= '0;
      run_q   <= '0;
      peak_q  <= '0;
      ppk_q   <= '0;
      half_q  <= '0;
      vol_q   <= '0;
      match_q <= '0;
      lock_q  <= 1'b0;
      mv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      have_q  <= have_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
      peak_q  <= peak_d;
      ppk_q   <= ppk_d;
      half_q  <= half_d;
      vol_q   <= vol_d;
      match_q <= match_d;
      lock_q  <= lock_d;
      mv_q    <= mv_d;
      to_q    <= to_d;
    end
  assign bus.half_period = half_q;
  assign bus.volume      = vol_q;
  assign bus.meas_valid  = mv_q;
  assign bus.locked      = lock_q;
  assign bus.timeout     = to_q;
endmodule
